// File: rtl/ws2811_serializer.sv
// rtl/ws2811_serializer.sv - WS2811 NRZ pixel serializer that walks ledcontroller's ledindex
//
// Sweeps ledindex across the strip one LED ahead of the LED on the wire. It samples
// the colour ledcontroller returns for that index and sends it as 24 pulse-width
// coded bits, MSB first. The LEDs of a frame follow each other with no gap, and a
// RESET_CYCLES low latch gap separates frames.
//
// Optional macro WS2811_GRB_ORDER_EN: when defined, each load takes {green,red,blue},
// so green bit 7 goes out first. Timing and ports are unchanged.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   red/green/blue  colour for the current ledindex (sampled only at load points)
//   ledindex     LED index presented to ledcontroller
//   dout         registered WS2811 serial data
//   busy         high while priming or shifting, low during the latch gap
//   frame_start  one-cycle pulse on the first shift cycle of LED 0
module ws2811_serializer #(
    parameter int NUM_LEDS      = 64,
    parameter int BIT_CYCLES    = 15,
    parameter int T0H_CYCLES    = 4,
    parameter int T1H_CYCLES    = 8,
    parameter int RESET_CYCLES  = 720,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] ledindex,
    output logic       dout,
    output logic       busy,
    output logic       frame_start
);

    localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(BIT_CYCLES - 1);
    localparam logic [BCW-1:0] T0H_V      = BCW'(T0H_CYCLES);
    localparam logic [BCW-1:0] T1H_V      = BCW'(T1H_CYCLES);
    localparam logic [15:0]    GAP_LAST   = 16'(RESET_CYCLES - 1);
    localparam logic [15:0]    PRIME_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]     LED_LAST   = 8'(NUM_LEDS - 1);
    localparam logic [8:0]     NUM_LEDS_W = 9'(NUM_LEDS);
    // With a single LED the prefetch index never leaves 0.
    localparam logic [7:0]     FIRST_IDX  = (NUM_LEDS == 1) ? 8'd0 : 8'd1;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_PRIME,
        ST_SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [BCW-1:0] bit_cyc_q, bit_cyc_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     led_cnt_q, led_cnt_d;
    logic [23:0]    shreg_q, shreg_d;
    logic [7:0]     ledindex_q, ledindex_d;
    logic           dout_q, dout_d;
    logic           frame_start_q, frame_start_d;

    logic [23:0]    load_word;
    logic [8:0]     led_next2;

`ifdef WS2811_GRB_ORDER_EN
    assign load_word = {green, red, blue};
`else
    assign load_word = {red, green, blue};
`endif

    // Index of the LED after the one about to be loaded; compared wide so that
    // NUM_LEDS=256 wraps cleanly to 0.
    assign led_next2 = {1'b0, led_cnt_q} + 9'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_GAP;
            cnt_q         <= '0;
            bit_cyc_q     <= '0;
            bit_cnt_q     <= '0;
            led_cnt_q     <= '0;
            shreg_q       <= '0;
            ledindex_q    <= '0;
            dout_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cyc_q     <= bit_cyc_d;
            bit_cnt_q     <= bit_cnt_d;
            led_cnt_q     <= led_cnt_d;
            shreg_q       <= shreg_d;
            ledindex_q    <= ledindex_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cyc_d     = bit_cyc_q;
        bit_cnt_d     = bit_cnt_q;
        led_cnt_d     = led_cnt_q;
        shreg_d       = shreg_q;
        ledindex_d    = ledindex_q;
        dout_d        = 1'b0;
        frame_start_d = 1'b0;

        unique case (state_q)
            ST_GAP: begin
                ledindex_d = 8'd0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_PRIME;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_PRIME: begin
                // ledindex has been 0 for the whole settle window, so the colour
                // inputs now hold LED 0.
                if (cnt_q == PRIME_LAST) begin
                    cnt_d         = 16'd0;
                    shreg_d       = load_word;
                    led_cnt_d     = 8'd0;
                    bit_cyc_d     = '0;
                    bit_cnt_d     = 5'd0;
                    ledindex_d    = FIRST_IDX;
                    frame_start_d = 1'b1;
                    state_d       = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_SHIFT: begin
                dout_d = (bit_cyc_q < (shreg_q[23] ? T1H_V : T0H_V));
                if (bit_cyc_q == BIT_LAST) begin
                    bit_cyc_d = '0;
                    shreg_d   = {shreg_q[22:0], 1'b0};
                    bit_cnt_d = (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        if (led_cnt_q < LED_LAST) begin
                            // Colour for led_cnt+1 has settled for a whole LED time.
                            shreg_d    = load_word;
                            led_cnt_d  = led_cnt_q + 8'd1;
                            ledindex_d = (led_next2 == NUM_LEDS_W) ? 8'd0 : led_next2[7:0];
                        end else begin
                            led_cnt_d  = 8'd0;
                            ledindex_d = 8'd0;
                            state_d    = ST_GAP;
                        end
                    end
                end else begin
                    bit_cyc_d = bit_cyc_q + BCW'(1);
                end
            end

            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    assign ledindex    = ledindex_q;
    assign dout        = dout_q;
    assign busy        = (state_q != ST_GAP);
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ws2811_serializer.sv
// tb/tb_ws2811_serializer.sv - self-checking bench for ws2811_serializer
module tb_ws2811_serializer;

    localparam int A_N = 3, A_B = 15, A_T0 = 4, A_T1 = 8, A_R = 720, A_S = 16;
    localparam int A_P = A_R + A_S + A_N * 24 * A_B;
    localparam int B_N = 256, B_B = 4, B_T0 = 1, B_T1 = 2, B_R = 8, B_S = 4;
    localparam int B_P = B_R + B_S + B_N * 24 * B_B;

`ifdef WS2811_GRB_ORDER_EN
    localparam bit GRB = 1'b1;
`else
    localparam bit GRB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // DUT A: 3 LEDs, default timing, random colour table per frame
    logic       rst_a;
    logic [7:0] red_a, green_a, blue_a, ledindex_a;
    logic       dout_a, busy_a, fs_a;
    logic [23:0] col_a [0:3];
    int         cnt_a;
    assign {red_a, green_a, blue_a} = col_a[ledindex_a[1:0]];

    // DUT B: 256 LEDs, short timing, controller returns {idx, ~idx, idx^5A}
    logic       rst_b;
    logic [7:0] red_b, green_b, blue_b, ledindex_b;
    logic       dout_b, busy_b, fs_b;
    int         cnt_b;
    assign red_b   = ledindex_b;
    assign green_b = ~ledindex_b;
    assign blue_b  = ledindex_b ^ 8'h5A;

    // DUT C: single LED, default timing, table-driven
    logic        rst_c;
    logic [23:0] rgb_c;
    logic [7:0]  ledindex_c;
    logic        dout_c, busy_c, fs_c;
    int          cnt_c;

    ws2811_serializer #(.NUM_LEDS(A_N), .BIT_CYCLES(A_B), .T0H_CYCLES(A_T0), .T1H_CYCLES(A_T1),
                        .RESET_CYCLES(A_R), .SETTLE_CYCLES(A_S)) dut_a (
        .clk(clk), .reset(rst_a), .red(red_a), .green(green_a), .blue(blue_a),
        .ledindex(ledindex_a), .dout(dout_a), .busy(busy_a), .frame_start(fs_a));

    ws2811_serializer #(.NUM_LEDS(B_N), .BIT_CYCLES(B_B), .T0H_CYCLES(B_T0), .T1H_CYCLES(B_T1),
                        .RESET_CYCLES(B_R), .SETTLE_CYCLES(B_S)) dut_b (
        .clk(clk), .reset(rst_b), .red(red_b), .green(green_b), .blue(blue_b),
        .ledindex(ledindex_b), .dout(dout_b), .busy(busy_b), .frame_start(fs_b));

    ws2811_serializer #(.NUM_LEDS(1), .BIT_CYCLES(A_B), .T0H_CYCLES(A_T0), .T1H_CYCLES(A_T1),
                        .RESET_CYCLES(A_R), .SETTLE_CYCLES(A_S)) dut_c (
        .clk(clk), .reset(rst_c), .red(rgb_c[23:16]), .green(rgb_c[15:8]), .blue(rgb_c[7:0]),
        .ledindex(ledindex_c), .dout(dout_c), .busy(busy_c), .frame_start(fs_c));

    // Rising edges since each DUT's reset release.
    always @(posedge clk) begin
        cnt_a <= rst_a ? 0 : cnt_a + 1;
        cnt_b <= rst_b ? 0 : cnt_b + 1;
        cnt_c <= rst_c ? 0 : cnt_c + 1;
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation still running at %0t, limit %0d", $time, 100000 * 10);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] ord(input logic [23:0] rgb);
        return GRB ? {rgb[15:8], rgb[23:16], rgb[7:0]} : rgb;
    endfunction

    // Reference timeline for DUT A, n = rising edges since release.
    function automatic int exp_dout_a(input int n);
        int u, b, p;
        logic [23:0] w;
        if (n < A_R + A_S + 1) return 0;
        u = (n - (A_R + A_S + 1)) % A_P;
        b = u / A_B;
        p = u % A_B;
        if (b >= A_N * 24) return 0;
        w = ord(col_a[b / 24]);
        return (p < (w[23 - (b % 24)] ? A_T1 : A_T0)) ? 1 : 0;
    endfunction

    function automatic int exp_busy_a(input int n);
        if (n < A_R) return 0;
        return (((n - A_R) % A_P) < A_S + A_N * 24 * A_B) ? 1 : 0;
    endfunction

    function automatic int exp_fs_a(input int n);
        if (n < A_R + A_S) return 0;
        return (((n - A_R - A_S) % A_P) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_idx_a(input int n);
        int v, w;
        if (n < A_R) return 0;
        v = (n - A_R) % A_P;
        if (v < A_S) return 0;
        w = v - A_S;
        if (w >= A_N * 24 * A_B) return 0;
        return ((w / (24 * A_B)) + 1) % A_N;
    endfunction

    task automatic randomize_a();
        for (int i = 0; i < 4; i++) col_a[i] = 24'($urandom);
    endtask

    // Cycle-by-cycle comparison against the reference; new colours are drawn
    // 100 cycles into each latch gap, when nothing is being loaded.
    task automatic run_a(input int n_end);
        while (cnt_a < n_end) begin
            @(negedge clk);
            chk("a_dout", dout_a, exp_dout_a(cnt_a));
            chk("a_busy", busy_a, exp_busy_a(cnt_a));
            chk("a_frame_start", fs_a, exp_fs_a(cnt_a));
            chk("a_ledindex", ledindex_a, exp_idx_a(cnt_a));
            if ((cnt_a % A_P) == 100) randomize_a();
        end
    endtask

    // Pulse-width decoder for DUT A.
    int          run_len_a = 0;
    int          nbits_a   = 0;
    logic [23:0] acc_a     = '0;
    logic [23:0] words_a[$];

    task automatic dec_a(input int n_end);
        logic bit_v;
        while (cnt_a < n_end) begin
            @(negedge clk);
            if (dout_a) run_len_a++;
            else if (run_len_a > 0) begin
                bit_v = (run_len_a > (A_T0 + A_T1) / 2);
                chk("a_pulse_width", run_len_a, bit_v ? A_T1 : A_T0);
                acc_a = {acc_a[22:0], bit_v};
                nbits_a++;
                if (nbits_a % 24 == 0) words_a.push_back(acc_a);
                run_len_a = 0;
            end
        end
    endtask

    typedef struct {
        int          n;
        logic [23:0] rgb;
        logic        dout;
        logic        busy;
        logic        fs;
        logic [7:0]  idx;
    } vec_t;

    vec_t tbl [0:31];
    int   nv = 0;

    task automatic add(input int n, input logic d, input logic b, input logic f);
        tbl[nv] = '{n, 24'hFF0000, d, b, f, 8'd0};
        nv++;
    endtask

    initial begin
        logic [23:0] exp_w [$];
        logic [7:0]  idxq [$];
        int          fsq [$];
        logic [23:0] words_b [$];
        logic [7:0]  prev_idx;
        logic [23:0] acc_b;
        int          run_b, nbits_b, tgt;
        logic        bit_v;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        rgb_c = 24'h0;
        randomize_a();
        repeat (3) @(negedge clk);

        chk("a_reset_dout", dout_a, 0);
        chk("a_reset_busy", busy_a, 0);
        chk("b_reset_fs", fs_b, 0);
        chk("c_reset_ledindex", ledindex_c, 0);

        // Single LED, FF/00/00: hand-computed timeline points.
        add(0, 0, 0, 0);     add(719, 0, 0, 0);   add(720, 0, 1, 0);   add(735, 0, 1, 0);
        add(736, 0, 1, 1);   add(737, 1, 1, 0);   add(740, 1, 1, 0);   add(741, !GRB, 1, 0);
        add(744, !GRB, 1, 0); add(745, 0, 1, 0);  add(751, 0, 1, 0);   add(752, 1, 1, 0);
        add(857, 1, 1, 0);   add(861, GRB, 1, 0); add(1082, 1, 1, 0);  add(1085, 1, 1, 0);
        add(1086, 0, 1, 0);  add(1095, 0, 1, 0);  add(1096, 0, 0, 0);  add(1097, 0, 0, 0);
        add(1815, 0, 0, 0);  add(1816, 0, 1, 0);  add(1832, 0, 1, 1);  add(1833, 1, 1, 0);

        rgb_c = tbl[0].rgb;
        rst_c = 1'b0;
        for (int i = 0; i < nv; i++) begin
            while (cnt_c < tbl[i].n) @(negedge clk);
            rgb_c = tbl[i].rgb;
            chk($sformatf("c_dout@%0d", tbl[i].n), dout_c, tbl[i].dout);
            chk($sformatf("c_busy@%0d", tbl[i].n), busy_c, tbl[i].busy);
            chk($sformatf("c_fs@%0d", tbl[i].n), fs_c, tbl[i].fs);
            chk($sformatf("c_idx@%0d", tbl[i].n), ledindex_c, tbl[i].idx);
        end
        rst_c = 1'b1;

        // Three LEDs with random colours, three frames against the reference.
        @(negedge clk);
        rst_a = 1'b0;
        run_a(3 * A_P);

        // Reset during the high phase of LED 1 bit 10 of frame 3.
        tgt = 3 * A_P + A_R + A_S + 1 + 37 * A_B + 1;
        run_a(tgt);
        chk("a_pre_reset_dout", dout_a, 1);
        rst_a = 1'b1;
        #1;
        chk("a_async_reset_dout", dout_a, 0);
        chk("a_async_reset_busy", busy_a, 0);
        chk("a_async_reset_fs", fs_a, 0);
        chk("a_async_reset_ledindex", ledindex_a, 0);
        repeat (2) @(negedge clk);
        randomize_a();
        rst_a = 1'b0;
        run_a(A_P);

        // Colour change in flight: decode frames 1..3 after the reset.
        for (int i = 0; i < 4; i++) col_a[i] = 24'h123456;
        dec_a(2 * A_P);
        for (int i = 0; i < 4; i++) col_a[i] = 24'hAA55CC;
        dec_a(2 * A_P + A_R + A_S + 1 + 42 * A_B + 2);
        for (int i = 0; i < 4; i++) col_a[i] = 24'h000000;
        dec_a(4 * A_P);

        repeat (3) exp_w.push_back(ord(24'h123456));
        repeat (2) exp_w.push_back(ord(24'hAA55CC));
        repeat (4) exp_w.push_back(24'h000000);
        chk("a_word_count", words_a.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < words_a.size(); i++)
            chk($sformatf("a_word%0d", i), words_a[i], exp_w[i]);

        // 256 LEDs: index wrap, bit count, frame period.
        rst_a = 1'b1;
        prev_idx = ledindex_b;
        acc_b = '0; run_b = 0; nbits_b = 0;
        rst_b = 1'b0;
        while (cnt_b < B_P + B_R + B_S + 2) begin
            @(negedge clk);
            if (fs_b) fsq.push_back(cnt_b);
            if (ledindex_b != prev_idx) begin
                idxq.push_back(ledindex_b);
                prev_idx = ledindex_b;
            end
            if (cnt_b <= B_P) begin
                if (dout_b) run_b++;
                else if (run_b > 0) begin
                    bit_v = (run_b > 1);
                    chk("b_pulse_width", run_b, bit_v ? B_T1 : B_T0);
                    acc_b = {acc_b[22:0], bit_v};
                    nbits_b++;
                    if (nbits_b % 24 == 0) words_b.push_back(acc_b);
                    run_b = 0;
                end
            end
        end

        chk("b_bits_per_frame", nbits_b, B_N * 24);
        chk("b_fs_count", fsq.size(), 2);
        if (fsq.size() == 2) begin
            chk("b_first_fs", fsq[0], B_R + B_S);
            chk("b_frame_period", fsq[1] - fsq[0], B_P);
        end
        chk("b_idx_changes", idxq.size(), 257);
        for (int k = 0; k < idxq.size() && k < 257; k++)
            chk($sformatf("b_idx_change%0d", k), idxq[k], (k + 1) % 256);
        for (int k = 0; k < words_b.size() && k < 256; k++)
            chk($sformatf("b_word%0d", k), words_b[k],
                ord({8'(k), ~8'(k), 8'(k) ^ 8'h5A}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ws2811_serializer.md
Name: ws2811_serializer

Overview:
- Downstream consumer of ledcontroller.
- Walks `ledindex` across the strip and samples the RGB that ledcontroller computes for each index.
- Serialises each colour as 24 NRZ pulse-width bits on a single WS2811 data line, then inserts the latch (reset) gap between frames.
- Top-level pixel engine: drives ledcontroller's `ledindex` input and the strip's DIN pin.

Parameters:
- NUM_LEDS, 64: LEDs per frame. Range 1..256.
- BIT_CYCLES, 15: clk cycles per data bit (1.25 us at 12 MHz).
- T0H_CYCLES, 4: high time of a '0' bit. Must be < T1H_CYCLES.
- T1H_CYCLES, 8: high time of a '1' bit. Must be < BIT_CYCLES.
- RESET_CYCLES, 720: low time between frames (>= 50 us). Must be >= 1.
- SETTLE_CYCLES, 16: wait after changing `ledindex` before sampling. Covers two full 8-phase ledcontroller passes; 24*BIT_CYCLES must be >= SETTLE_CYCLES.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- red, input, 8: colour from ledcontroller for the current `ledindex`.
- green, input, 8: colour from ledcontroller for the current `ledindex`.
- blue, input, 8: colour from ledcontroller for the current `ledindex`.
- ledindex, output, 8: LED index presented to ledcontroller.
- dout, output, 1: WS2811 serial data.
- busy, output, 1: high while priming or shifting; low during the reset gap.
- frame_start, output, 1: one-cycle pulse on the first cycle of LED 0 bit 23.

Behaviour:
- Reset values: `dout`=0, `ledindex`=0, `busy`=0, `frame_start`=0. State=GAP, all counters 0, shift register 0.
- Reset asserted mid-bit aborts immediately: `dout` drops low the same instant and no partial bit completes.
- States:
  - GAP: `dout`=0, `ledindex`=0. Count RESET_CYCLES clocks, then go to PRIME.
  - PRIME: `busy`=1, `dout`=0. Count SETTLE_CYCLES clocks. On the last cycle, load `shreg` <= {red,green,blue}, set `led_cnt`=0, `ledindex`<=1 (0 if NUM_LEDS=1), then go to SHIFT.
  - SHIFT: `busy`=1. For each bit, MSB first (`shreg[23]` = red bit 7):
    - `bit_cyc` runs 0..BIT_CYCLES-1.
    - `dout`=1 while `bit_cyc` < (`shreg[23]` ? T1H_CYCLES : T0H_CYCLES), else 0.
    - At `bit_cyc`=BIT_CYCLES-1: shift `shreg` left 1 and increment `bit_cnt`.
  - End of bit 0 of an LED (`bit_cnt`=23 at `bit_cyc`=BIT_CYCLES-1):
    - If `led_cnt` < NUM_LEDS-1: load `shreg` <= {red,green,blue} (the prefetched next LED), `led_cnt`++, `ledindex` <= `led_cnt`+2, or 0 when `led_cnt`+2 = NUM_LEDS. Continue in SHIFT with no gap between LEDs.
    - Otherwise go to GAP.
- Prefetch rule: `ledindex` always leads the LED being shifted by one. The data line is therefore continuous across a whole frame.
- `dout` is registered; the first high edge of a bit appears one clk after the state/count update.
- `frame_start` asserts on the first SHIFT cycle after PRIME.
- Widths:
  - `bit_cyc`: clog2(BIT_CYCLES) bits.
  - `bit_cnt`: 5 bits, wraps 23 -> 0.
  - GAP/PRIME counter: 16 bits.
  - `led_cnt`: 8 bits.
- Inputs are sampled only at load points; changes elsewhere have no effect on the LED in flight.

Optional Feature:
- Macro WS2811_GRB_ORDER_EN.
- Defined: loads use {green,red,blue}, so green bit 7 is sent first (WS2812-style strips).
- Undefined: {red,green,blue} order as above.
- Timing, state machine and ports are identical in both cases.

Test Plan:
1. Reset release, NUM_LEDS=1, rgb=FF/00/00:
   - `dout` low for 720 cycles, then `busy` high 16 cycles.
   - Then 8 bits of high 8 / low 7, followed by 16 bits of high 4 / low 11.
   - Then 720 low; `frame_start` pulses once per frame.
2. NUM_LEDS=3, controller model returns rgb={idx,idx,idx}:
   - Decoded stream is 000000, 010101, 020202.
   - `ledindex` sequence is 0,1,2,0; no low gap > BIT_CYCLES-T0H between LEDs.
3. Assert reset at LED 1 bit 10 high phase:
   - `dout`=0 within the same cycle and all outputs at reset values.
   - After release, a full 720-cycle gap precedes the next frame.
4. Change rgb mid-LED (bit 5) from AA/55/CC to 00/00/00:
   - LED in flight still decodes AA55CC; the new value appears only on the next load.
5. NUM_LEDS=256:
   - `ledindex` wraps 255 -> 0 correctly; 256*24 bits emitted per frame.
   - Frame period = 720+16+256*24*15 cycles.
6. WS2811_GRB_ORDER_EN defined, rgb=12/34/56:
   - Decoded 24-bit word is 341256; bit timing matches scenario 1.
